// File: rtl/fifo_rd_packer_pkg.sv
// Shared definitions for the FIFO read-side packer.
//   state_e   : packer control states (idle, filling, flushing a partial beat)
//   Def*      : default parameter values used by the interface and modules
package fifo_rd_packer_pkg;

   localparam int unsigned DefWidth = 8;
   localparam int unsigned DefPack  = 4;
   localparam int unsigned DefCntW  = 16;

   typedef enum logic [1:0] {
      StIdle,
      StFill,
      StFlush
   } state_e;

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Bus bundle between a read-side FIFO, the packer and the downstream consumer.
//   fifo_empty / fifo_rdata / fifo_rd_en : FIFO read port (data valid one cycle after a pop)
//   flush                                : request to emit a partially filled beat
//   m_valid / m_ready / m_data / m_keep  : packed output stream, lane i = bits i*WIDTH
//   beat_cnt                             : running count of transferred beats
// slave is the packer side, master is the environment side.
interface fifo_rd_packer_if
   import fifo_rd_packer_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned PACK  = DefPack,
   parameter int unsigned CNT_W = DefCntW
);

   logic                  fifo_empty;
   logic [WIDTH-1:0]      fifo_rdata;
   logic                  fifo_rd_en;
   logic                  flush;
   logic                  m_valid;
   logic                  m_ready;
   logic [WIDTH*PACK-1:0] m_data;
   logic [PACK-1:0]       m_keep;
   logic [CNT_W-1:0]      beat_cnt;

   modport slave (
      input  fifo_empty, fifo_rdata, flush, m_ready,
      output fifo_rd_en, m_valid, m_data, m_keep, beat_cnt
   );

   modport master (
      output fifo_empty, fifo_rdata, flush, m_ready,
      input  fifo_rd_en, m_valid, m_data, m_keep, beat_cnt
   );

endinterface

// File: rtl/fifo_rd_packer_pack_out_reg.sv
// Output stage of the packer: one beat register with valid/ready handshake and beat counter.
//   clk_rd, rst_n : read-domain clock, asynchronous active-low reset
//   i_load        : capture i_data/i_keep (only asserted when o_free is high)
//   i_ready       : downstream accept
//   o_valid/o_data/o_keep : held beat, stable while stalled
//   o_beat_cnt    : transferred beats, wraps
//   o_free        : register empty or draining this cycle, so a new beat may load
module pack_out_reg #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned PACK  = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic                  clk_rd,
   input  logic                  rst_n,
   input  logic                  i_load,
   input  logic [WIDTH*PACK-1:0] i_data,
   input  logic [PACK-1:0]       i_keep,
   input  logic                  i_ready,
   output logic                  o_valid,
   output logic [WIDTH*PACK-1:0] o_data,
   output logic [PACK-1:0]       o_keep,
   output logic [CNT_W-1:0]      o_beat_cnt,
   output logic                  o_free
);

   logic                  r_valid;
   logic [WIDTH*PACK-1:0] r_data;
   logic [PACK-1:0]       r_keep;
   logic [CNT_W-1:0]      r_beat_cnt;
   logic                  w_xfer;

   assign w_xfer = r_valid && i_ready;
   assign o_free = !r_valid || i_ready;

   always_ff @(posedge clk_rd or negedge rst_n) begin
      if (!rst_n) begin
         r_valid    <= 1'b0;
         r_data     <= '0;
         r_keep     <= '0;
         r_beat_cnt <= '0;
      end else begin
         if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_keep  <= i_keep;
         end else if (w_xfer) begin
            r_valid <= 1'b0;
         end
         if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
         end
      end
   end

   assign o_valid    = r_valid;
   assign o_data     = r_data;
   assign o_keep     = r_keep;
   assign o_beat_cnt = r_beat_cnt;

endmodule

// File: rtl/fifo_rd_packer.sv
// Packs PACK consecutive FIFO words into one wide beat; first-popped word lands in lane 0.
// A flush request closes a partially filled beat with a matching keep mask.
//   clk_rd, rst_n : read-domain clock, asynchronous active-low reset
//   bus (slave)   : FIFO read port, flush request and packed output stream
module fifo_rd_packer
   import fifo_rd_packer_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned PACK  = DefPack,
   parameter int unsigned CNT_W = DefCntW
) (
   input  logic              clk_rd,
   input  logic              rst_n,
   fifo_rd_packer_if.slave   bus
);

   localparam int unsigned IdxW  = $clog2(PACK);
   localparam int unsigned LaneW = IdxW + 1;
   localparam logic [LaneW-1:0] LaneFull = LaneW'(PACK);
   localparam logic [LaneW-1:0] LaneLast = LaneW'(PACK - 1);

   state_e                      r_state, w_state_d;
   logic [LaneW-1:0]            r_lane_cnt;
   logic                        r_inflight;
   logic [PACK-1:0][WIDTH-1:0]  r_acc;

   logic                        w_flush_pend;
   logic                        w_pop;
   logic                        w_out_free;
   logic                        w_full_xfer;
   logic                        w_part_xfer;
   logic                        w_load;
   logic                        w_completing;
   logic [PACK-1:0]             w_keep;
   logic [WIDTH*PACK-1:0]       w_data;

   assign w_flush_pend = (r_state == StFlush);

   // Gated by rst_n so no pop is requested while held in reset.
   assign w_pop = rst_n && !bus.fifo_empty && !w_flush_pend &&
                  ((r_lane_cnt + LaneW'(r_inflight)) < LaneFull);
   assign bus.fifo_rd_en = w_pop;

   assign w_full_xfer  = (r_lane_cnt == LaneFull) && w_out_free;
   assign w_part_xfer  = w_flush_pend && !r_inflight && w_out_free;
   assign w_load       = w_full_xfer || w_part_xfer;
   // Accumulator is full or its last lane is being written: a flush now is redundant.
   assign w_completing = (r_lane_cnt == LaneFull) || (r_inflight && (r_lane_cnt == LaneLast));

   // Keep covers filled lanes; all ones for a full beat. Unfilled lanes are zeroed.
   always_comb begin
      w_keep = '0;
      w_data = '0;
      for (int i = 0; i < int'(PACK); i++) begin
         w_keep[i] = (LaneW'(i) < r_lane_cnt);
         w_data[i*WIDTH +: WIDTH] = w_keep[i] ? r_acc[i] : '0;
      end
   end

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (w_pop) w_state_d = StFill;
         StFill: begin
            if (w_full_xfer) begin
               w_state_d = StIdle;
            end else if (bus.flush && !w_completing) begin
               w_state_d = StFlush;
            end
         end
         StFlush: if (w_part_xfer) w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_rd or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // A lane write and a transfer never coincide: both transfer paths require no data in flight.
   always_ff @(posedge clk_rd or negedge rst_n) begin
      if (!rst_n) begin
         r_lane_cnt <= '0;
         r_inflight <= 1'b0;
         r_acc      <= '0;
      end else begin
         r_inflight <= w_pop;
         if (r_inflight) begin
            r_acc[r_lane_cnt[IdxW-1:0]] <= bus.fifo_rdata;
            r_lane_cnt                  <= r_lane_cnt + LaneW'(1);
         end else if (w_load) begin
            r_lane_cnt <= '0;
         end
      end
   end

   pack_out_reg #(
      .WIDTH (WIDTH),
      .PACK  (PACK),
      .CNT_W (CNT_W)
   ) u_out (
      .clk_rd     (clk_rd),
      .rst_n      (rst_n),
      .i_load     (w_load),
      .i_data     (w_data),
      .i_keep     (w_keep),
      .i_ready    (bus.m_ready),
      .o_valid    (bus.m_valid),
      .o_data     (bus.m_data),
      .o_keep     (bus.m_keep),
      .o_beat_cnt (bus.beat_cnt),
      .o_free     (w_out_free)
   );

endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 Parameter WIDTH, default 8: FIFO word width in bits.
REQ-002 Parameter PACK, default 4: FIFO words packed per output beat (power of two, >=2).
REQ-003 Parameter CNT_W, default 16: width of the emitted-beat counter.
REQ-004 clk_rd  input  1  read-domain clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 fifo_empty  input  1  FIFO read-side empty flag.
REQ-007 fifo_rdata  input  WIDTH  FIFO read data, valid the cycle after fifo_rd_en is sampled high.
REQ-008 fifo_rd_en  output  1  pop request to FIFO.
REQ-009 flush  input  1  single-cycle request to emit a partial word.
REQ-010 m_valid  output  1  output beat valid.
REQ-011 m_ready  input  1  downstream accept; a beat transfers when m_valid && m_ready.
REQ-012 m_data  output  WIDTH*PACK  packed beat; first-popped word in bits [WIDTH-1:0].
REQ-013 m_keep  output  PACK  per-lane valid mask, lane i = bit i.
REQ-014 beat_cnt  output  CNT_W  count of transferred beats, wraps modulo 2^CNT_W.

Function
REQ-015 fifo_rd_en SHALL be combinational: !fifo_empty && !flush_pend && (lane_cnt + inflight) < PACK; it SHALL never be high while fifo_empty is high (no underflow).
REQ-016 inflight SHALL be a register set to 1 in the cycle after a pop, and 0 otherwise (at most one pop in flight).
REQ-017 When inflight is 1, fifo_rdata SHALL be written into accumulator lane lane_cnt, and lane_cnt SHALL increment.
REQ-018 When lane_cnt reaches PACK, the accumulator SHALL transfer to the output register if the output register is empty or is transferring this cycle; otherwise the accumulator SHALL hold and no pop SHALL issue.
REQ-019 A full transfer SHALL set m_valid=1, m_keep=all ones, and lane_cnt=0; latency from the last lane write to m_valid SHALL be 1 cycle.
REQ-020 m_valid, m_data and m_keep SHALL stay stable while m_valid && !m_ready.
REQ-021 States: IDLE (lane_cnt=0, no inflight), FILL (0<lane_cnt<PACK or inflight), FLUSH (flush_pend=1).
REQ-022 IDLE->FILL on pop; FILL->IDLE on full transfer; IDLE/FILL->FLUSH on flush=1; FLUSH->IDLE on partial transfer.
REQ-023 flush while in IDLE with no inflight SHALL be ignored; no beat SHALL be emitted.
REQ-024 In FLUSH, pops SHALL stop; once inflight=0 and the output register is free, the accumulator SHALL transfer with m_keep=(1<<lane_cnt)-1; unused lanes SHALL be zero.
REQ-025 flush arriving while flush_pend=1 SHALL be absorbed.
REQ-026 flush coinciding with a full-word completion SHALL emit the full word only, then return to IDLE.
REQ-027 beat_cnt SHALL increment on every transfer, both full and partial.

Reset
REQ-028 While rst_n=0, the following SHALL be 0: m_valid, m_data, m_keep, beat_cnt, lane_cnt, inflight, flush_pend, and fifo_rd_en; state SHALL be IDLE.
REQ-029 Reset mid-operation SHALL discard the accumulated lanes, any inflight data and the pending beat; there is no partial output.
REQ-030 Release SHALL be used as-is; the upstream synchronizer owns deassertion timing.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, FILL, FLUSH) and the defaults WIDTH=8 and PACK=4.
REQ-032 One sub-module, pack_out_reg, SHALL hold the output register and valid/ready stall logic; the packer core SHALL drive it.
REQ-033 Target size is 150-300 lines of RTL.

Verification
REQ-034 FIFO preloaded with 8'h11,22,33,44 and m_ready=1 -> one beat, m_data=32'h44332211, m_keep=4'hF, beat_cnt=1.
REQ-035 fifo_empty=1 for 50 cycles -> fifo_rd_en never high, m_valid=0.
REQ-036 8 words pushed and m_ready=0 for 20 cycles -> first beat held stable, accumulator full, fifo_rd_en=0; after m_ready=1 -> two beats, beat_cnt=2.
REQ-037 Words 8'hA1,B2,C3 followed by a flush pulse -> m_data=32'h00C3B2A1, m_keep=4'h7.
REQ-038 flush pulse in IDLE -> no beat, and beat_cnt unchanged.
REQ-039 rst_n dropped after 2 of 4 lanes are filled -> all outputs 0; after release, a fresh 4-word sequence packs from lane 0.
